// File: rtl/axi_lite_adder_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_adder_slave
//   AXI4-Lite target holding two writable operands (A, B) and exposing their
//   registered sum (RESULT) and a STATUS word for readback.
//   Register map relative to BASE_ADDR:
//     +0x0 OPERAND_A (RW)   +0x4 OPERAND_B (RW)
//     +0x8 RESULT    (RO)   +0xC STATUS    (RO)
//   STATUS: bit0 carry, bit1 result valid, [15:8] OKAY write count,
//           [23:16] OKAY read count, all other bits zero.
//
// Ports
//   s_axi_aclk, s_axi_areset        clock, synchronous active-high reset
//   s_axi_aw*/s_axi_w*/s_axi_b*     write address / data / response channels
//   s_axi_ar*/s_axi_r*              read address / data channels
//   s_axi_wstrb has one spare MSB which is ignored.
// ---------------------------------------------------------------------------
module axi_lite_adder_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] ADDR_A    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B    = ADDR_WIDTH'(BASE_ADDR + 4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RES  = ADDR_WIDTH'(BASE_ADDR + 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STAT = ADDR_WIDTH'(BASE_ADDR + 12);

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [1:0] {W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Byte-lane merge of new write data into an existing register value.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic [ADDR_WIDTH-1:0] awaddr_held;
  logic [DATA_WIDTH-1:0] wdata_held;
  logic [STRB_W-1:0]     wstrb_held;

  logic [DATA_WIDTH-1:0] reg_a, reg_b;
  logic [DATA_WIDTH-1:0] result_p1;
  logic                  carry_p1;
  logic                  vld_p0;
  logic                  status_vld;
  logic [7:0]            wr_count, rd_count;

  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [STRB_W-1:0]     wr_strb_c;
  logic                  wr_okay;
  logic [DATA_WIDTH:0]   sum_c;

  logic                  ar_hs;
  logic                  rd_okay;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] status_word;

  logic                  unused_wstrb_msb;
  assign unused_wstrb_msb = s_axi_wstrb[STRB_W];

  // The channel that arrived first is taken from its holding register,
  // the completing channel straight from the bus.
  assign wr_addr_c = (w_state == W_ADDR_HELD) ? awaddr_held : s_axi_awaddr;
  assign wr_data_c = (w_state == W_DATA_HELD) ? wdata_held  : s_axi_wdata;
  assign wr_strb_c = (w_state == W_DATA_HELD) ? wstrb_held  : s_axi_wstrb[STRB_W-1:0];
  assign wr_okay   = (wr_addr_c == ADDR_A) || (wr_addr_c == ADDR_B);

  assign sum_c = {1'b0, reg_a} + {1'b0, reg_b};

  // Write FSM: next state and channel handshakes
  always_comb begin
    w_state_n     = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    commit        = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        if (s_axi_awvalid && s_axi_wvalid) begin
          commit    = 1'b1;
          w_state_n = W_RESP;
        end else if (s_axi_awvalid) begin
          w_state_n = W_ADDR_HELD;
        end else if (s_axi_wvalid) begin
          w_state_n = W_DATA_HELD;
        end
      end
      W_ADDR_HELD: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          commit    = 1'b1;
          w_state_n = W_RESP;
        end
      end
      W_DATA_HELD: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) begin
          commit    = 1'b1;
          w_state_n = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state     <= W_IDLE;
      awaddr_held <= '0;
      wdata_held  <= '0;
      wstrb_held  <= '0;
      s_axi_bresp <= RESP_OKAY;
      reg_a       <= '0;
      reg_b       <= '0;
      wr_count    <= '0;
      vld_p0      <= 1'b0;
      result_p1   <= '0;
      carry_p1    <= 1'b0;
      status_vld  <= 1'b0;
    end else begin
      w_state <= w_state_n;
      if (s_axi_awvalid && s_axi_awready) awaddr_held <= s_axi_awaddr;
      if (s_axi_wvalid && s_axi_wready) begin
        wdata_held <= s_axi_wdata;
        wstrb_held <= s_axi_wstrb[STRB_W-1:0];
      end
      if (commit) begin
        s_axi_bresp <= wr_okay ? RESP_OKAY : RESP_SLVERR;
        if (wr_addr_c == ADDR_A) reg_a <= merge_bytes(reg_a, wr_data_c, wr_strb_c);
        if (wr_addr_c == ADDR_B) reg_b <= merge_bytes(reg_b, wr_data_c, wr_strb_c);
        if (wr_okay) wr_count <= wr_count + 8'd1;
      end
      // p0: an accepted operand write requests a sum update
      vld_p0 <= commit && wr_okay;
      // p1: sum of the freshly written operands lands in RESULT/CARRY
      if (vld_p0) begin
        result_p1 <= sum_c[DATA_WIDTH-1:0];
        carry_p1  <= sum_c[DATA_WIDTH];
      end
      // Valid drops while an update is in flight, rises once it has landed.
      if (commit && wr_okay) status_vld <= 1'b0;
      else if (vld_p0)       status_vld <= 1'b1;
    end
  end

  always_comb begin
    status_word        = '0;
    status_word[0]     = carry_p1;
    status_word[1]     = status_vld;
    status_word[15:8]  = wr_count;
    status_word[23:16] = rd_count;
  end

  // Exact-match decode: misaligned or out-of-window addresses fall to default.
  always_comb begin
    rd_word = '0;
    rd_okay = 1'b1;
    case (s_axi_araddr)
      ADDR_A:    rd_word = reg_a;
      ADDR_B:    rd_word = reg_b;
      ADDR_RES:  rd_word = result_p1;
      ADDR_STAT: rd_word = status_word;
      default:   rd_okay = 1'b0;
    endcase
  end

  // Read FSM: next state and channel handshakes
  always_comb begin
    r_state_n     = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    ar_hs         = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          ar_hs     = 1'b1;
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state     <= R_IDLE;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
      rd_count    <= '0;
    end else begin
      r_state <= r_state_n;
      if (ar_hs) begin
        s_axi_rdata <= rd_word;
        s_axi_rresp <= rd_okay ? RESP_OKAY : RESP_SLVERR;
        if (rd_okay) rd_count <= rd_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_adder_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_adder_slave
//   Self-checking bench for axi_lite_adder_slave (instantiated at BASE 16).
//   A behavioural register-map model tracks A, B, RESULT, CARRY, valid and
//   the transaction counters; directed scenarios plus random traffic are
//   compared against it.
// ---------------------------------------------------------------------------
module tb_axi_lite_adder_slave;

  localparam int BASE = 16;
  localparam logic [2:0] OKAY   = 3'd0;
  localparam logic [2:0] SLVERR = 3'd2;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [4:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [2:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [2:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_a, m_b, m_res;
  bit          m_carry, m_vld;
  int          m_wr, m_rd;

  always #5 clk = ~clk;

  axi_lite_adder_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(BASE)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (areset),
    .s_axi_awaddr (awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready)
  );

  // ---------------- reference model ----------------
  function automatic bit m_wr_ok(input logic [7:0] a);
    return (int'(a) == BASE) || (int'(a) == BASE + 4);
  endfunction

  function automatic bit m_rd_ok(input logic [7:0] a);
    int ai;
    ai = int'(a);
    return (ai >= BASE) && (ai <= BASE + 12) && (ai % 4 == 0);
  endfunction

  function automatic logic [31:0] m_status();
    return {8'h00, 8'(m_rd), 8'(m_wr), 6'h00, m_vld, m_carry};
  endfunction

  function automatic logic [31:0] m_read_val(input logic [7:0] a);
    if (!m_rd_ok(a)) return 32'h0;
    case (int'(a) - BASE)
      0:       return m_a;
      4:       return m_b;
      8:       return m_res;
      default: return m_status();
    endcase
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_res = 0; m_carry = 0; m_vld = 0; m_wr = 0; m_rd = 0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
    longint sum;
    if (!m_wr_ok(a)) return;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        if (int'(a) == BASE) m_a[8*i +: 8] = d[8*i +: 8];
        else                 m_b[8*i +: 8] = d[8*i +: 8];
      end
    end
    m_wr    = (m_wr + 1) % 256;
    sum     = longint'(m_a) + longint'(m_b);
    m_res   = sum[31:0];
    m_carry = (sum >= 64'h1_0000_0000);
    m_vld   = 1;
  endtask

  task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] r);
    d = m_read_val(a);
    r = m_rd_ok(a) ? OKAY : SLVERR;
    if (m_rd_ok(a)) m_rd = (m_rd + 1) % 256;
  endtask

  // ---------------- bus drivers (entered #1 after a posedge) ----------------
  task automatic do_reset();
    areset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    @(posedge clk); @(posedge clk); #1;
    areset = 0;
    model_reset();
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                           output logic [2:0] resp);
    bit aw_done, w_done, aw_hs, w_hs, got;
    int cyc;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 20) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 0; aw_done = 1; end
      if (w_hs)  begin wvalid = 0;  w_done = 1;  end
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) begin
      n_checks++; n_fail++;
      $display("FAIL write_handshake_timeout addr=%h got=no-accept exp=accept", a);
    end
    resp = 3'bx; bready = 1; got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      if (bvalid) begin got = 1; resp = bresp; end
      @(posedge clk); #1;
      cyc++;
    end
    bready = 0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL bvalid_timeout addr=%h got=0 exp=1", a);
    end
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] resp);
    bit done, hs, got;
    int cyc;
    araddr = a; arvalid = 1; done = 0; cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) begin arvalid = 0; done = 1; end
      cyc++;
    end
    arvalid = 0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL ar_handshake_timeout addr=%h got=no-accept exp=accept", a);
    end
    d = 32'hx; resp = 3'bx; rready = 1; got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      if (rvalid) begin got = 1; d = rdata; resp = rresp; end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL rvalid_timeout addr=%h got=0 exp=1", a);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d, ed;
    logic [2:0]  r, er;
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      n_fail++;
      $display("FAIL reset_handshakes got=%b exp=11100", {awready, wready, arready, bvalid, rvalid});
    end
    n_checks++;
    if ({bresp, rresp, rdata} !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h/%h/%h exp=0/0/0", bresp, rresp, rdata);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      model_read(8'(BASE + 4*k), ed, er);
      axi_read(8'(BASE + 4*k), d, r);
      n_checks++;
      if (d !== ed || r !== er) begin
        n_fail++;
        $display("FAIL reset_readback off=%0d got=%h/%0d exp=%h/%0d", 4*k, d, r, ed, er);
      end
    end
  endtask

  task automatic test_basic_sum();
    logic [31:0] d, ed;
    logic [2:0]  r, er;
    logic [7:0]  addrs [2];
    logic [31:0] vals  [2];
    addrs[0] = 8'(BASE); vals[0] = 32'h5;
    addrs[1] = 8'(BASE + 4); vals[1] = 32'h7;
    for (int k = 0; k < 2; k++) begin
      model_write(addrs[k], vals[k], 5'h0F);
      axi_write(addrs[k], vals[k], 5'h0F, r);
      n_checks++;
      if (r !== OKAY) begin n_fail++; $display("FAIL basic_bresp k=%0d got=%0d exp=0", k, r); end
    end
    model_read(8'(BASE + 8), ed, er);
    axi_read(8'(BASE + 8), d, r);
    n_checks++;
    if (d !== 32'hC || ed !== 32'hC || r !== OKAY) begin
      n_fail++;
      $display("FAIL basic_result got=%h/%0d exp=0000000c/0", d, r);
    end
  endtask

  task automatic test_carry();
    logic [31:0] d, ed;
    logic [2:0]  r, er;
    do_reset();
    model_write(8'(BASE), 32'hFFFF_FFFF, 5'h0F); axi_write(8'(BASE), 32'hFFFF_FFFF, 5'h0F, r);
    model_write(8'(BASE + 4), 32'h1, 5'h0F);     axi_write(8'(BASE + 4), 32'h1, 5'h0F, r);
    model_read(8'(BASE + 8), ed, er);
    axi_read(8'(BASE + 8), d, r);
    n_checks++;
    if (d !== 32'h0 || r !== OKAY) begin
      n_fail++; $display("FAIL carry_result got=%h/%0d exp=00000000/0", d, r);
    end
    model_read(8'(BASE + 12), ed, er);
    axi_read(8'(BASE + 12), d, r);
    n_checks++;
    if (d[1:0] !== 2'b11 || d[15:8] !== 8'd2) begin
      n_fail++; $display("FAIL carry_status_bits got=%h exp=carry1 valid1 wr2", d);
    end
    n_checks++;
    if (d !== ed || r !== er) begin
      n_fail++; $display("FAIL carry_status_word got=%h/%0d exp=%h/%0d", d, r, ed, er);
    end
  endtask

  task automatic test_split_channels();
    logic [31:0] d, ed;
    logic [2:0]  r, er;
    logic [31:0] v;
    logic [7:0]  a;
    a = 8'(BASE + 4);
    for (int ord = 0; ord < 2; ord++) begin
      v = (ord == 0) ? 32'h10 : 32'h210;
      awaddr = a; wdata = v; wstrb = 5'h0F;
      if (ord == 0) awvalid = 1; else wvalid = 1;
      @(negedge clk);
      n_checks++;
      if ((ord == 0 ? awready : wready) !== 1'b1) begin
        n_fail++; $display("FAIL split_first_ready ord=%0d got=0 exp=1", ord);
      end
      @(posedge clk); #1;
      if (ord == 0) begin awvalid = 0; wvalid = 1; end
      else          begin wvalid = 0;  awvalid = 1; end
      @(negedge clk);
      n_checks++;
      if ({bvalid, awready, wready} !== (ord == 0 ? 3'b001 : 3'b010)) begin
        n_fail++;
        $display("FAIL split_held ord=%0d got=%b exp=%b", ord, {bvalid, awready, wready},
                 (ord == 0 ? 3'b001 : 3'b010));
      end
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== OKAY) begin
        n_fail++; $display("FAIL split_bvalid_latency ord=%0d got=%b/%0d exp=1/0", ord, bvalid, bresp);
      end
      model_write(a, v, 5'h0F);
      bready = 1; @(posedge clk); #1; bready = 0;
      model_read(a, ed, er);
      axi_read(a, d, r);
      n_checks++;
      if (d !== ed || r !== er) begin
        n_fail++; $display("FAIL split_readback ord=%0d got=%h exp=%h", ord, d, ed);
      end
    end
  endtask

  task automatic test_strobes();
    logic [31:0] d, ed, v;
    logic [2:0]  r, er;
    logic [4:0]  s;
    logic [7:0]  a;
    model_write(8'(BASE), 32'h1122_3344, 5'h0F); axi_write(8'(BASE), 32'h1122_3344, 5'h0F, r);
    model_write(8'(BASE), 32'h0000_AA00, 5'h02); axi_write(8'(BASE), 32'h0000_AA00, 5'h02, r);
    model_read(8'(BASE), ed, er);
    axi_read(8'(BASE), d, r);
    n_checks++;
    if (d !== 32'h1122_AA44 || r !== OKAY) begin
      n_fail++; $display("FAIL strobe_byte1 got=%h/%0d exp=1122aa44/0", d, r);
    end
    // zero strobe (with the spare MSB set) is OKAY and leaves data alone
    model_write(8'(BASE), 32'hDEAD_BEEF, 5'h10); axi_write(8'(BASE), 32'hDEAD_BEEF, 5'h10, r);
    n_checks++;
    if (r !== OKAY) begin n_fail++; $display("FAIL strobe_zero_bresp got=%0d exp=0", r); end
    for (int k = 0; k < 6; k++) begin
      a = 8'(BASE + 4 * (k % 2));
      v = $urandom;
      s = 5'($urandom_range(0, 31));
      model_write(a, v, s); axi_write(a, v, s, r);
      model_read(a, ed, er); axi_read(a, d, r);
      n_checks++;
      if (d !== ed || r !== er) begin
        n_fail++; $display("FAIL strobe_random k=%0d strb=%h got=%h exp=%h", k, s, d, ed);
      end
    end
    model_read(8'(BASE + 12), ed, er); axi_read(8'(BASE + 12), d, r);
    n_checks++;
    if (d !== ed) begin n_fail++; $display("FAIL strobe_status got=%h exp=%h", d, ed); end
  endtask

  task automatic test_errors();
    logic [31:0] d, ed;
    logic [2:0]  r, er;
    logic [7:0]  wa [3];
    logic [7:0]  ra [3];
    wa[0] = 8'(BASE + 8); wa[1] = 8'(BASE + 12); wa[2] = 8'(BASE - 4);
    ra[0] = 8'h40;        ra[1] = 8'(BASE + 2);  ra[2] = 8'(BASE + 16);
    for (int k = 0; k < 3; k++) begin
      model_write(wa[k], 32'hFFFF_FFFF, 5'h0F);
      axi_write(wa[k], 32'hFFFF_FFFF, 5'h0F, r);
      n_checks++;
      if (r !== SLVERR) begin n_fail++; $display("FAIL err_write k=%0d got=%0d exp=2", k, r); end
      model_read(ra[k], ed, er);
      axi_read(ra[k], d, r);
      n_checks++;
      if (r !== SLVERR || d !== 32'h0) begin
        n_fail++; $display("FAIL err_read k=%0d got=%h/%0d exp=00000000/2", k, d, r);
      end
    end
    for (int k = 0; k < 4; k++) begin
      model_read(8'(BASE + 4*k), ed, er);
      axi_read(8'(BASE + 4*k), d, r);
      n_checks++;
      if (d !== ed || r !== er) begin
        n_fail++; $display("FAIL err_unchanged off=%0d got=%h exp=%h", 4*k, d, ed);
      end
    end
  endtask

  task automatic test_pipeline();
    logic [31:0] d, ed, exp_stat;
    logic [2:0]  r, er;
    do_reset();
    model_write(8'(BASE + 4), 32'h1, 5'h0F); axi_write(8'(BASE + 4), 32'h1, 5'h0F, r);
    model_write(8'(BASE), 32'h0, 5'h0F);     axi_write(8'(BASE), 32'h0, 5'h0F, r);
    // read handshake on the same edge as the write commit sees pre-write state
    awaddr = 8'(BASE); wdata = 32'hFFFF_FFFF; wstrb = 5'h0F; awvalid = 1; wvalid = 1;
    araddr = 8'(BASE + 12); arvalid = 1;
    exp_stat = m_status();
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    model_write(8'(BASE), 32'hFFFF_FFFF, 5'h0F);
    m_rd = (m_rd + 1) % 256;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== exp_stat) begin
      n_fail++; $display("FAIL pipe_same_edge got=%b/%h exp=1/%h", rvalid, rdata, exp_stat);
    end
    bready = 1; rready = 1; @(posedge clk); #1; bready = 0; rready = 0;
    // read one edge after commit lands while the sum update is in flight
    awaddr = 8'(BASE); wdata = 32'h0; wstrb = 5'h0F; awvalid = 1; wvalid = 1; bready = 1;
    exp_stat = {8'h00, 8'(m_rd), 8'((m_wr + 1) % 256), 6'h00, 1'b0, m_carry};
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    araddr = 8'(BASE + 12); arvalid = 1;
    @(negedge clk);
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== OKAY) begin
      n_fail++; $display("FAIL pipe_bvalid got=%b/%0d exp=1/0", bvalid, bresp);
    end
    @(posedge clk); #1;
    arvalid = 0; bready = 0;
    model_write(8'(BASE), 32'h0, 5'h0F);
    m_rd = (m_rd + 1) % 256;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== exp_stat) begin
      n_fail++; $display("FAIL pipe_inflight_status got=%b/%h exp=1/%h", rvalid, rdata, exp_stat);
    end
    rready = 1; @(posedge clk); #1; rready = 0;
    for (int k = 2; k < 4; k++) begin
      model_read(8'(BASE + 4*k), ed, er);
      axi_read(8'(BASE + 4*k), d, r);
      n_checks++;
      if (d !== ed || r !== er) begin
        n_fail++; $display("FAIL pipe_settled off=%0d got=%h exp=%h", 4*k, d, ed);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, ed, exp_rd;
    logic [2:0]  r, er;
    awaddr = 8'(BASE); wdata = 32'hCAFE_F00D; wstrb = 5'h0F; awvalid = 1; wvalid = 1;
    araddr = 8'(BASE); arvalid = 1; bready = 0; rready = 0;
    exp_rd = m_a;
    @(posedge clk); #1;
    model_write(8'(BASE), 32'hCAFE_F00D, 5'h0F);
    m_rd = (m_rd + 1) % 256;
    // fresh requests stay asserted while both responses are stalled
    awaddr = 8'(BASE + 4); wdata = 32'h5555_AAAA; araddr = 8'(BASE + 4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bvalid, rvalid, awready, wready, arready} !== 5'b11000) begin
        n_fail++;
        $display("FAIL hold_handshakes cyc=%0d got=%b exp=11000", k,
                 {bvalid, rvalid, awready, wready, arready});
      end
      n_checks++;
      if (bresp !== OKAY || rresp !== OKAY || rdata !== exp_rd) begin
        n_fail++; $display("FAIL hold_data cyc=%0d got=%h/%0d exp=%h/0", k, rdata, rresp, exp_rd);
      end
      @(posedge clk); #1;
    end
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    @(negedge clk);
    n_checks++;
    if ({bvalid, rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL hold_release got=%b exp=00", {bvalid, rvalid});
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      model_read(8'(BASE + 4*k), ed, er);
      axi_read(8'(BASE + 4*k), d, r);
      n_checks++;
      if (d !== ed || r !== er) begin
        n_fail++; $display("FAIL hold_readback off=%0d got=%h exp=%h", 4*k, d, ed);
      end
    end
    // reset while the write response is pending drops it
    awaddr = 8'(BASE + 4); wdata = 32'h1234; wstrb = 5'h0F; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    n_checks++;
    if (bvalid !== 1'b1) begin n_fail++; $display("FAIL abort_pre got=%b exp=1", bvalid); end
    areset = 1;
    @(posedge clk); #1;
    areset = 0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_fail++; $display("FAIL abort_bvalid got=%b exp=011", {bvalid, awready, wready});
    end
    @(posedge clk); #1;
    model_read(8'(BASE + 4), ed, er);
    axi_read(8'(BASE + 4), d, r);
    n_checks++;
    if (d !== ed || r !== er) begin
      n_fail++; $display("FAIL abort_regs got=%h exp=%h", d, ed);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, ed, v;
    logic [2:0]  r, er;
    logic [4:0]  s;
    logic [7:0]  a;
    int sel;
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 4);
      a = (sel < 4) ? 8'(BASE + 4*sel) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom;
        s = 5'($urandom_range(0, 31));
        er = m_wr_ok(a) ? OKAY : SLVERR;
        model_write(a, v, s);
        axi_write(a, v, s, r);
        n_checks++;
        if (r !== er) begin
          n_fail++; $display("FAIL random_bresp k=%0d addr=%h got=%0d exp=%0d", k, a, r, er);
        end
      end else begin
        model_read(a, ed, er);
        axi_read(a, d, r);
        n_checks++;
        if (d !== ed || r !== er) begin
          n_fail++;
          $display("FAIL random_read k=%0d addr=%h got=%h/%0d exp=%h/%0d", k, a, d, r, ed, er);
        end
      end
    end
  endtask

  initial begin
    areset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    model_reset();
    test_reset();
    test_basic_sum();
    test_carry();
    test_split_channels();
    test_strobes();
    test_errors();
    test_pipeline();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
